rx_port_buffer: RTL and testbench

- Per-port ingress stage directly upstream of the switch core; one instance per router port.
- Accepts SpaceWire N-Chars from the CODEC receiver into a first-word-fall-through (FWFT) FIFO.
- Decodes and deletes the path-address header, then requests the destination output port from the switch matrix.
- Once granted, streams the remaining packet through a FIFO-style read handshake up to and including EOP/EEP.

---
 rtl/rx_port_buffer.sv | 139 +++++++++++++
 tb/tb_rx_port_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_port_buffer.sv
// Router ingress port: FWFT FIFO for CODEC N-Chars, path-address header
// decode/delete, output-port request and packet streaming to the switch matrix.
module rx_port_buffer #(
  parameter int unsigned DW      = 8,
  parameter int unsigned PortNUM = 16,
  parameter int unsigned PW      = 4,
  parameter int unsigned AW      = 4
) (
  input  logic          gclk,
  input  logic          reset,
  input  logic [DW:0]   char_i,
  input  logic          wr_i,
  output logic          full_o,
  output logic          req_o,
  output logic [PW-1:0] dest_o,
  input  logic          grant_i,
  output logic [DW:0]   dout,
  output logic          empty_o,
  input  logic          rd_i,
  output logic [7:0]    err_cnt_o
);

  localparam int unsigned CW    = DW + 1;
  localparam int unsigned PTRW  = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, REQ, XFER, DISCARD} state_e;

  state_e          state_q, state_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            full_q, full_d;
  logic            fifo_empty_q, fifo_empty_d;
  logic            empty_q, empty_d;
  logic            req_q, req_d;
  logic [PW-1:0]   dest_q, dest_d;
  logic [7:0]      err_q, err_d;
  logic [CW-1:0]   dout_q, dout_d;
  logic [CW-1:0]   mem [DEPTH];

  logic            wr_en;
  logic            pop;
  logic            head_end;
  logic            head_addr_ok;

  // Any control character at the head terminates the packet (EOP, EEP or unknown)
  assign head_end     = dout_q[DW];
  assign head_addr_ok = 32'(dout_q[DW-1:0]) < PortNUM;
  assign wr_en        = wr_i & ~full_q;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    dest_d  = dest_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty_q) begin
          pop = 1'b1;
          if (!head_end) begin
            if (head_addr_ok) begin
              dest_d  = PW'(dout_q[DW-1:0]);
              state_d = REQ;
            end else begin
              state_d = DISCARD;
              if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end
          end
        end
      end
      REQ: begin
        if (grant_i) state_d = XFER;
      end
      XFER: begin
        if (rd_i && !empty_q) begin
          pop = 1'b1;
          if (head_end) state_d = IDLE;
        end
      end
      DISCARD: begin
        if (!fifo_empty_q) begin
          pop = 1'b1;
          if (head_end) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer/flag next state; dout_d forwards a write landing directly on the new head
  always_comb begin
    wr_ptr_d     = wr_ptr_q + PTRW'(wr_en);
    rd_ptr_d     = rd_ptr_q + PTRW'(pop);
    fifo_empty_d = (wr_ptr_d == rd_ptr_d);
    full_d       = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    dout_d       = mem[rd_ptr_d[AW-1:0]];
    if (wr_en && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) dout_d = char_i;
    req_d        = (state_d == REQ) || (state_d == XFER);
    empty_d      = (state_d == XFER) ? fifo_empty_d : 1'b1;
  end

  always_ff @(posedge gclk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= char_i;
  end

  always_ff @(posedge gclk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      full_q       <= 1'b0;
      fifo_empty_q <= 1'b1;
      empty_q      <= 1'b1;
      req_q        <= 1'b0;
      dest_q       <= '0;
      err_q        <= '0;
      dout_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      full_q       <= full_d;
      fifo_empty_q <= fifo_empty_d;
      empty_q      <= empty_d;
      req_q        <= req_d;
      dest_q       <= dest_d;
      err_q        <= err_d;
      dout_q       <= dout_d;
    end
  end

  assign full_o    = full_q;
  assign req_o     = req_q;
  assign dest_o    = dest_q;
  assign dout      = dout_q;
  assign empty_o   = empty_q;
  assign err_cnt_o = err_q;

endmodule

// File: tb/tb_rx_port_buffer.sv
// Scoreboard bench for rx_port_buffer: expected payload chars are queued at
// stimulus time and checked by an independent monitor as the matrix pops them.
module tb_rx_port_buffer;

  logic       gclk;
  logic       reset;
  logic [8:0] char_i;
  logic       wr_i;
  logic       full_o;
  logic       req_o;
  logic [3:0] dest_o;
  logic       grant_i;
  logic [8:0] dout;
  logic       empty_o;
  logic       rd_i;
  logic [7:0] err_cnt_o;

  logic [8:0] sb [$];
  logic [8:0] exp_c;
  int n_tests = 0;
  int n_fail  = 0;

  rx_port_buffer #(.DW(8), .PortNUM(16), .PW(4), .AW(4)) dut (
    .gclk(gclk), .reset(reset), .char_i(char_i), .wr_i(wr_i), .full_o(full_o),
    .req_o(req_o), .dest_o(dest_o), .grant_i(grant_i), .dout(dout),
    .empty_o(empty_o), .rd_i(rd_i), .err_cnt_o(err_cnt_o)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic put(input logic [8:0] c);
    char_i = c;
    wr_i   = 1'b1;
    tick();
  endtask

  task automatic wait_req_low(input string name, input int bound);
    int k = 0;
    while (req_o && k < bound) begin
      tick();
      k++;
    end
    chk(name, 32'(req_o), 0);
  endtask

  // Monitor: a pop happens at the next edge whenever rd_i=1 and empty_o=0
  initial forever begin
    @(negedge gclk);
    if (reset && rd_i && !empty_o) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dout_unexpected: got 0x%0h expected nothing", dout);
      end else begin
        exp_c = sb.pop_front();
        chk("dout", 32'(dout), 32'(exp_c));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; wr_i = 1'b0; rd_i = 1'b0; grant_i = 1'b0; char_i = '0;
    tick(); tick();
    chk("rst_full",  32'(full_o), 0);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_req",   32'(req_o), 0);
    chk("rst_dest",  32'(dest_o), 0);
    chk("rst_err",   32'(err_cnt_o), 0);
    chk("rst_dout",  32'(dout), 0);
    reset = 1'b1;
    tick();

    // Basic route to port 5
    rd_i = 1'b1;
    sb.push_back(9'h011); sb.push_back(9'h022); sb.push_back(9'h100);
    put(9'h005);
    chk("route_req_not_yet", 32'(req_o), 0);
    put(9'h011);
    chk("route_req", 32'(req_o), 1);
    chk("route_dest", 32'(dest_o), 5);
    grant_i = 1'b1;
    put(9'h022);
    put(9'h100);
    wr_i = 1'b0;
    chk("route_req_hold1", 32'(req_o), 1);
    tick();
    chk("route_req_hold2", 32'(req_o), 1);
    tick();
    chk("route_req_drop", 32'(req_o), 0);
    grant_i = 1'b0;

    // Invalid address is discarded
    put(9'h020);
    put(9'h0AA);
    chk("inv_err", 32'(err_cnt_o), 1);
    chk("inv_req", 32'(req_o), 0);
    chk("inv_empty", 32'(empty_o), 1);
    put(9'h0BB);
    put(9'h101);
    wr_i = 1'b0;
    tick(); tick();
    chk("inv_req_end", 32'(req_o), 0);
    chk("inv_empty_end", 32'(empty_o), 1);
    chk("inv_err_end", 32'(err_cnt_o), 1);

    // Empty packet
    put(9'h100);
    wr_i = 1'b0;
    tick();
    chk("emptypkt_req", 32'(req_o), 0);
    tick();
    chk("emptypkt_err", 32'(err_cnt_o), 1);

    // Overflow: header popped, 16 payload stored, 17th dropped
    rd_i = 1'b0;
    put(9'h003);
    for (int i = 1; i <= 17; i++) begin
      if (i <= 16) sb.push_back(9'(48 + i));
      put(9'(48 + i));
      if (i == 1) begin
        chk("ovf_req", 32'(req_o), 1);
        chk("ovf_dest", 32'(dest_o), 3);
      end
      if (i == 15) chk("ovf_not_full15", 32'(full_o), 0);
      if (i == 16) chk("ovf_full16", 32'(full_o), 1);
      if (i == 17) chk("ovf_full17", 32'(full_o), 1);
    end
    wr_i = 1'b0;
    grant_i = 1'b1;
    tick();
    rd_i = 1'b1;
    tick();
    chk("ovf_full_clear", 32'(full_o), 0);
    sb.push_back(9'h100);
    put(9'h100);
    wr_i = 1'b0;
    wait_req_low("ovf_req_drop", 40);
    grant_i = 1'b0;

    // Back-to-back packets to ports 0 and 15
    grant_i = 1'b1;
    sb.push_back(9'h041); sb.push_back(9'h100);
    sb.push_back(9'h042); sb.push_back(9'h101);
    put(9'h000);
    put(9'h041);
    chk("b2b_req0", 32'(req_o), 1);
    chk("b2b_dest0", 32'(dest_o), 0);
    put(9'h100);
    put(9'h00F);
    put(9'h042);
    chk("b2b_gap", 32'(req_o), 0);
    put(9'h101);
    chk("b2b_req1", 32'(req_o), 1);
    chk("b2b_dest1", 32'(dest_o), 15);
    wr_i = 1'b0;
    wait_req_low("b2b_req_drop", 10);

    // Asynchronous reset mid-packet flushes everything
    grant_i = 1'b0;
    rd_i = 1'b0;
    put(9'h007);
    put(9'h002);
    put(9'h066);
    wr_i = 1'b0;
    chk("rstmid_req_before", 32'(req_o), 1);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_empty", 32'(empty_o), 1);
    chk("rstmid_req", 32'(req_o), 0);
    chk("rstmid_full", 32'(full_o), 0);
    chk("rstmid_dest", 32'(dest_o), 0);
    tick();
    reset = 1'b1;
    grant_i = 1'b1;
    rd_i = 1'b1;
    repeat (4) tick();
    chk("rstmid_no_partial_req", 32'(req_o), 0);
    chk("rstmid_no_partial_empty", 32'(empty_o), 1);
    grant_i = 1'b0;
    rd_i = 1'b0;

    // Error counter saturation
    for (int p = 0; p < 260; p++) begin
      put(9'h0FF);
      put(9'h101);
      if (p == 9)   chk("sat_err10", 32'(err_cnt_o), 10);
      if (p == 254) chk("sat_err255", 32'(err_cnt_o), 255);
    end
    wr_i = 1'b0;
    repeat (3) tick();
    chk("sat_err_hold", 32'(err_cnt_o), 255);
    chk("sat_req", 32'(req_o), 0);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
